// File: rtl/ext_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// ext_mem_arbiter_pkg
//   Shared types and constants for the external memory access arbiter:
//   arbiter FSM states, request operation kind, memory read/write mode codes
//   and the statistics counter width. Also provides a saturating increment
//   used by the optional statistics counters.
// -----------------------------------------------------------------------------
package ext_mem_arbiter_pkg;

  // Memory port access-width modes (shared with the memory block).
  typedef enum logic [2:0] {
    ReadWriteMode_NONE     = 3'd0,
    ReadWriteMode_BYTE     = 3'd1,
    ReadWriteMode_HALFWORD = 3'd2,
    ReadWriteMode_WORD     = 3'd3
  } ReadWriteModes;

  typedef enum logic [2:0] {
    IDLE,
    FREEZE,
    ACCESS,
    ACK,
    WAIT_DROP,
    RESUME
  } ext_arb_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } ext_arb_op_t;

  localparam int STAT_W = 16;

  // Width of the dwell-time down-counter; comfortably covers the
  // settle / latency / hold parameters.
  localparam int CNT_W = 8;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ext_mem_arbiter_delay_counter.sv
// -----------------------------------------------------------------------------
// arb_delay_counter
//   Loadable down-counter with a zero flag, used to time how long the arbiter
//   dwells in a state. A load takes priority; otherwise the count decrements
//   and parks at zero.
// Ports
//   clk        in   system clock
//   rst        in   asynchronous, active-low reset (count cleared)
//   load_i     in   load load_val_i on this edge
//   load_val_i in   value to load (dwell cycles minus one)
//   zero_o     out  count is zero (final cycle of the dwell)
// -----------------------------------------------------------------------------
module arb_delay_counter
  import ext_mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d (no latch).
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ext_mem_arbiter.sv
// -----------------------------------------------------------------------------
// ext_mem_arbiter
//   Sequences a serial-command access to the processor's shared memory port:
//   freezes the processor clock enable, lets the pipeline settle, drives the
//   memory external-control lines for one WORD read or write, returns a
//   one-cycle ack (with read data), waits for the request to drop and then
//   resumes the processor after a one-cycle guard.
//
//   Optional build macro: EXT_MEM_ARB_STATS_EN adds saturating completed
//   read/write counters (stat_rd_count, stat_wr_count).
//
// Parameters
//   SETTLE_CYCLES  cycles frozen before memory is driven (>=1)
//   READ_LATENCY   cycles memory is driven for a read; data sampled on last (>=1)
//   WRITE_HOLD     cycles memory is driven for a write (>=1)
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   req_write / req_read      level requests (write wins if both)
//   req_addr / req_wdata      request address / write data, latched on accept
//   req_ack                   one-cycle completion pulse
//   req_rdata                 last read word, held until next read completes
//   busy                      high whenever the arbiter is not idle
//   proc_clk_en               processor clock enable (1 = run)
//   mem_ext_ctrl              memory external-control select
//   mem_addr / mem_wdata      memory address / write data
//   mem_read_mode / mem_write_mode  WORD while accessing, otherwise NONE
//   mem_rdata                 memory read data
//   stat_rd_count / stat_wr_count   (EXT_MEM_ARB_STATS_EN only)
// -----------------------------------------------------------------------------
module ext_mem_arbiter
  import ext_mem_arbiter_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_HOLD    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_write,
  input  logic              req_read,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ack,
  output logic [31:0]       req_rdata,
  output logic              busy,
  output logic              proc_clk_en,
  output logic              mem_ext_ctrl,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_read_mode,
  output logic [2:0]        mem_write_mode,
  input  logic [31:0]       mem_rdata
`ifdef EXT_MEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_rd_count,
  output logic [STAT_W-1:0] stat_wr_count
`endif
);

  // Counter load values are dwell length minus one: the zero flag marks the
  // final cycle of the dwell, on whose closing edge the FSM moves on.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LOAD   = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WRITE_LOAD  = CNT_W'(WRITE_HOLD - 1);

  ext_arb_state_t state_q;
  ext_arb_op_t    op_q;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;

  logic           req_ack_q;
  logic [31:0]    req_rdata_q;
  logic           busy_q;
  logic           proc_clk_en_q;
  logic           mem_ext_ctrl_q;
  logic [31:0]    mem_addr_q;
  logic [31:0]    mem_wdata_q;
  ReadWriteModes  mem_read_mode_q;
  ReadWriteModes  mem_write_mode_q;

  logic             req_any;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;

  assign req_any = req_write | req_read;

  // Reload the dwell counter on entry to FREEZE (from IDLE) and on entry to
  // ACCESS (from FREEZE); other states do not use it.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = SETTLE_LOAD;
    if (state_q == IDLE && req_any) begin
      cnt_load     = 1'b1;
      cnt_load_val = SETTLE_LOAD;
    end else if (state_q == FREEZE && cnt_zero) begin
      cnt_load     = 1'b1;
      cnt_load_val = (op_q == OP_WRITE) ? WRITE_LOAD : READ_LOAD;
    end
  end

  arb_delay_counter u_dwell (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  // All outputs are registered and updated on the edge that changes state,
  // so nothing on req_* reaches an output combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      op_q             <= OP_READ;
      // NOTE: the request latches are reset as well so a reset mid-access
      // leaves no stale address or data on the memory lines.
      addr_q           <= '0;
      wdata_q          <= '0;
      req_ack_q        <= 1'b0;
      req_rdata_q      <= '0;
      busy_q           <= 1'b0;
      proc_clk_en_q    <= 1'b1;
      mem_ext_ctrl_q   <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      mem_read_mode_q  <= ReadWriteMode_NONE;
      mem_write_mode_q <= ReadWriteMode_NONE;
    end else begin
      req_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_any) begin
            // Write wins when both requests arrive together.
            op_q          <= req_write ? OP_WRITE : OP_READ;
            addr_q        <= req_addr;
            wdata_q       <= req_wdata;
            proc_clk_en_q <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= FREEZE;
          end
        end

        FREEZE: begin
          if (cnt_zero) begin
            mem_ext_ctrl_q <= 1'b1;
            mem_addr_q     <= addr_q;
            mem_wdata_q    <= wdata_q;
            if (op_q == OP_WRITE) begin
              mem_write_mode_q <= ReadWriteMode_WORD;
            end else begin
              mem_read_mode_q  <= ReadWriteMode_WORD;
            end
            state_q <= ACCESS;
          end
        end

        ACCESS: begin
          if (cnt_zero) begin
            // Last driven cycle: capture read data as the lines are released.
            if (op_q == OP_READ) begin
              req_rdata_q <= mem_rdata;
            end
            mem_ext_ctrl_q   <= 1'b0;
            mem_read_mode_q  <= ReadWriteMode_NONE;
            mem_write_mode_q <= ReadWriteMode_NONE;
            state_q          <= ACK;
          end
        end

        ACK: begin
          req_ack_q <= 1'b1;
          state_q   <= WAIT_DROP;
        end

        WAIT_DROP: begin
          // A request still held from the completed access must not retrigger.
          if (!req_any) begin
            proc_clk_en_q <= 1'b1;
            state_q       <= RESUME;
          end
        end

        RESUME: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ack        = req_ack_q;
  assign req_rdata      = req_rdata_q;
  assign busy           = busy_q;
  assign proc_clk_en    = proc_clk_en_q;
  assign mem_ext_ctrl   = mem_ext_ctrl_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_read_mode  = mem_read_mode_q;
  assign mem_write_mode = mem_write_mode_q;

`ifdef EXT_MEM_ARB_STATS_EN
  logic [STAT_W-1:0] stat_rd_q;
  logic [STAT_W-1:0] stat_wr_q;

  // Counted in the ACK state, so an access aborted by reset is never counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
    end else if (state_q == ACK) begin
      if (op_q == OP_READ) begin
        stat_rd_q <= sat_inc(stat_rd_q);
      end else begin
        stat_wr_q <= sat_inc(stat_wr_q);
      end
    end
  end

  assign stat_rd_count = stat_rd_q;
  assign stat_wr_count = stat_wr_q;
`endif

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ext_mem_arbiter
//   Self-checking bench for ext_mem_arbiter. A driver issues requests and pushes
//   the expected response (op, address, data, ack cycle, drive length) into a
//   scoreboard queue; a monitor on the falling edge checks every memory-drive
//   cycle and every ack against the queue head. Expected read data comes from
//   a reference memory map updated by the driver at request time; the bench's
//   memory model is updated only by what the DUT actually writes.
// -----------------------------------------------------------------------------
module tb_ext_mem_arbiter;
  import ext_mem_arbiter_pkg::*;

  localparam int SETTLE = 2;
  localparam int RLAT   = 2;
  localparam int WHOLD  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_write, req_read;
  logic [31:0] req_addr, req_wdata;
  logic        req_ack;
  logic [31:0] req_rdata;
  logic        busy, proc_clk_en, mem_ext_ctrl;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_read_mode, mem_write_mode;
  logic [31:0] mem_rdata = 32'h0;
`ifdef EXT_MEM_ARB_STATS_EN
  logic [STAT_W-1:0] stat_rd_count, stat_wr_count;
`endif

  always #5 clk = ~clk;

  ext_mem_arbiter #(
    .SETTLE_CYCLES (SETTLE),
    .READ_LATENCY  (RLAT),
    .WRITE_HOLD    (WHOLD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_write      (req_write),
    .req_read       (req_read),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ack        (req_ack),
    .req_rdata      (req_rdata),
    .busy           (busy),
    .proc_clk_en    (proc_clk_en),
    .mem_ext_ctrl   (mem_ext_ctrl),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_read_mode  (mem_read_mode),
    .mem_write_mode (mem_write_mode),
    .mem_rdata      (mem_rdata)
`ifdef EXT_MEM_ARB_STATS_EN
    ,
    .stat_rd_count  (stat_rd_count),
    .stat_wr_count  (stat_wr_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // ---------------- memory model (environment) ----------------
  logic [31:0] mem_store [logic [31:0]];

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // Memory answers only while selected in WORD read mode; writes land only
  // while selected in WORD write mode.
  always @(negedge clk) begin
    if (mem_ext_ctrl && mem_write_mode == ReadWriteMode_WORD)
      mem_store[mem_addr] = mem_wdata;
    if (mem_ext_ctrl && mem_read_mode == ReadWriteMode_WORD)
      mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : mem_default(mem_addr);
    else
      mem_rdata = 32'h0BAD_0BAD;
  end

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
  endfunction

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          len;
    int          ack_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   ack_seen = 0;
  int   exp_rd   = 0;
  int   exp_wr   = 0;

  // ---------------- monitor ----------------
  int drive_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      drive_cnt = 0;
    end else begin
      check("no_mem_drive_while_running", 32'(mem_ext_ctrl & proc_clk_en), 32'd0);
      if (mem_ext_ctrl) begin
        check("drive_has_pending_req", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          drive_cnt++;
          check("mem_addr", mem_addr, sb_q[0].addr);
          if (sb_q[0].is_write) begin
            check("write_mode_word", 32'(mem_write_mode), 32'(ReadWriteMode_WORD));
            check("read_mode_none_on_write", 32'(mem_read_mode), 32'(ReadWriteMode_NONE));
            check("mem_wdata", mem_wdata, sb_q[0].wdata);
          end else begin
            check("read_mode_word", 32'(mem_read_mode), 32'(ReadWriteMode_WORD));
            check("write_mode_none_on_read", 32'(mem_write_mode), 32'(ReadWriteMode_NONE));
          end
        end
      end
      if (req_ack) begin
        check("ack_has_pending_req", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
          check("drive_length", 32'(drive_cnt), 32'(e.len));
          check("mem_released_at_ack", 32'(mem_ext_ctrl), 32'd0);
          check("proc_frozen_at_ack", 32'(proc_clk_en), 32'd0);
          if (!e.is_write) check("req_rdata", req_rdata, e.rdata);
          if (e.is_write) exp_wr++;
          else            exp_rd++;
          drive_cnt = 0;
          ack_seen++;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_within_budget", 32'(busy), 32'd0);
  endtask

  task automatic do_access(input bit wr, input bit rd, input logic [31:0] a,
                           input logic [31:0] d, input int extra_hold, input bit drop_early);
    exp_t e;
    int   start_acks;
    wait_idle();
    req_write  = wr;
    req_read   = rd;
    req_addr   = a;
    req_wdata  = d;
    start_acks = ack_seen;
    @(posedge clk);
    #1;
    e.is_write = wr;
    e.addr     = a;
    e.wdata    = d;
    e.rdata    = wr ? 32'h0 : ref_read(a);
    e.len      = wr ? WHOLD : RLAT;
    e.ack_cyc  = cyc + SETTLE + e.len + 1;
    if (wr) ref_mem[a] = d;
    sb_q.push_back(e);
    check("proc_frozen_after_accept", 32'(proc_clk_en), 32'd0);
    check("busy_after_accept", 32'(busy), 32'd1);
    if (drop_early) begin
      @(negedge clk);
      req_write = 1'b0;
      req_read  = 1'b0;
    end
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      if (ack_seen != start_acks) break;
    end
    check("ack_within_budget", 32'(ack_seen - start_acks), 32'd1);
    if (!drop_early) begin
      for (int i = 0; i < extra_hold; i++) begin
        @(negedge clk);
        check("held_req_stays_frozen", 32'(proc_clk_en), 32'd0);
        check("held_req_stays_busy", 32'(busy), 32'd1);
      end
      @(negedge clk);
      req_write = 1'b0;
      req_read  = 1'b0;
    end
    wait_idle();
    check("proc_resumed", 32'(proc_clk_en), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    req_write = 1'b0;
    req_read  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rst       = 1'b0;
    mem_store[32'h0000_0010] = 32'hDEAD_BEEF;
    ref_mem[32'h0000_0010]   = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    check("rst_proc_clk_en", 32'(proc_clk_en), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_rdata", req_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b1;

    // Idle: nothing happens over 100 cycles.
    repeat (100) @(negedge clk);
    check("idle_ack_count", 32'(ack_seen), 32'd0);
    check("idle_proc_clk_en", 32'(proc_clk_en), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ext_ctrl", 32'(mem_ext_ctrl), 32'd0);
    check("idle_read_mode", 32'(mem_read_mode), 32'(ReadWriteMode_NONE));
    check("idle_write_mode", 32'(mem_write_mode), 32'(ReadWriteMode_NONE));

    // Directed read, write, read-back.
    do_access(1'b0, 1'b1, 32'h0000_0010, 32'h0, 2, 1'b0);
    check("read_deadbeef_held", req_rdata, 32'hDEAD_BEEF);
    do_access(1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678, 0, 1'b0);
    check("rdata_held_over_write", req_rdata, 32'hDEAD_BEEF);
    do_access(1'b0, 1'b1, 32'h0000_0020, 32'h0, 0, 1'b0);

    // Both requests at once: write wins; held 20 cycles after ack.
    do_access(1'b1, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 20, 1'b0);
    do_access(1'b0, 1'b1, 32'h0000_0030, 32'h0, 0, 1'b0);

    // Request dropped right after accept still completes.
    do_access(1'b0, 1'b1, 32'h0000_0020, 32'h0, 0, 1'b1);

    // Reset in the middle of ACCESS aborts without an ack.
    begin
      exp_t e;
      int   acks_before;
      wait_idle();
      req_read    = 1'b1;
      req_addr    = 32'h0000_0040;
      acks_before = ack_seen;
      e.is_write  = 1'b0;
      e.addr      = 32'h0000_0040;
      e.wdata     = '0;
      e.rdata     = ref_read(32'h0000_0040);
      e.len       = RLAT;
      e.ack_cyc   = -1;
      sb_q.push_back(e);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (mem_ext_ctrl) break;
      end
      check("reached_access", 32'(mem_ext_ctrl), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("abort_proc_clk_en", 32'(proc_clk_en), 32'd1);
      check("abort_ext_ctrl", 32'(mem_ext_ctrl), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_no_ack", 32'(req_ack), 32'd0);
      check("abort_read_mode", 32'(mem_read_mode), 32'(ReadWriteMode_NONE));
      sb_q.delete();
      req_read = 1'b0;
      exp_rd   = 0;
      exp_wr   = 0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("abort_ack_count", 32'(ack_seen - acks_before), 32'd0);
      do_access(1'b0, 1'b1, 32'h0000_0040, 32'h0, 1, 1'b0);
    end

    // Randomized traffic over a small address window so reads hit writes.
    for (int n = 0; n < 30; n++) begin
      int          kind;
      logic [31:0] a;
      kind = int'($urandom_range(0, 2));
      a    = 32'h0000_0100 + 32'($urandom_range(0, 7)) * 4;
      do_access(kind != 0, kind != 1, a, $urandom, int'($urandom_range(0, 3)),
                bit'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
`ifdef EXT_MEM_ARB_STATS_EN
    check("stat_rd_count", 32'(stat_rd_count), 32'(exp_rd));
    check("stat_wr_count", 32'(stat_wr_count), 32'(exp_wr));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
